// File: rtl/core_pkg.sv
// Shared core constants and helpers for the integer register file.
package core_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int REG_ZERO      = 0;
    localparam int MAX_REGS      = 64;
    localparam int CNT_W         = $clog2(MAX_REGS) + 1;

    // Narrower busy vectors are zero-extended by the caller.
    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_REGS-1:0] vec);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_REGS; i++) begin
            n = n + CNT_W'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the scoreboarded register file.
interface regfile_sb_if
    import core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NUM_RD = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NUM_RD*AW-1:0]   i_rd_sel;
    logic [NUM_RD*XLEN-1:0] o_rd_data;
    logic [NUM_RD-1:0]      o_rd_busy;
    logic                   i_wr_en;
    logic [AW-1:0]          i_wr_sel;
    logic [XLEN-1:0]        i_wr_data;
    logic                   i_rsv_en;
    logic [AW-1:0]          i_rsv_sel;
    logic                   o_rsv_ack;
    logic                   i_flush;
    logic [AW:0]            o_busy_cnt;

    modport master (
        output i_rd_sel, i_wr_en, i_wr_sel, i_wr_data, i_rsv_en, i_rsv_sel, i_flush,
        input  o_rd_data, o_rd_busy, o_rsv_ack, o_busy_cnt
    );

    modport slave (
        input  i_rd_sel, i_wr_en, i_wr_sel, i_wr_data, i_rsv_en, i_rsv_sel, i_flush,
        output o_rd_data, o_rd_busy, o_rsv_ack, o_busy_cnt
    );

endinterface

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: zero register, write bypass and busy qualification.
module regfile_sb_rdport
    import core_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [AW-1:0]   i_sel,
    input  logic            i_wr_en,
    input  logic [AW-1:0]   i_wr_sel,
    input  logic [XLEN-1:0] i_wr_data,
    input  logic [XLEN-1:0] i_arr_data,
    input  logic            i_arr_busy,
    output logic [XLEN-1:0] o_data,
    output logic            o_busy
);

    logic wr_hit;
    logic is_zero;

    always_comb begin
        wr_hit  = i_wr_en && (i_wr_sel == i_sel);
        is_zero = (ZERO_REG != 0) && (i_sel == AW'(REG_ZERO));

        if (is_zero) begin
            o_data = '0;
        end else if ((BYPASS != 0) && wr_hit) begin
            o_data = i_wr_data;
        end else begin
            o_data = i_arr_data;
        end

        // Without bypass the in-flight write is not yet readable, so it still counts as pending.
        if (is_zero) begin
            o_busy = 1'b0;
        end else if (BYPASS != 0) begin
            o_busy = i_arr_busy && !wr_hit;
        end else begin
            o_busy = i_arr_busy || wr_hit;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write bypass and a per-register busy scoreboard.
module regfile_sb
    import core_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         i_CLK,
    input  logic         i_RST,
    regfile_sb_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;

    logic wr_drop;
    logic rsv_zero;
    logic rsv_release;
    logic rsv_ack;

    always_comb begin
        wr_drop     = (ZERO_REG != 0) && (bus.i_wr_sel == AW'(REG_ZERO));
        rsv_zero    = (ZERO_REG != 0) && (bus.i_rsv_sel == AW'(REG_ZERO));
        rsv_release = bus.i_wr_en && (bus.i_wr_sel == bus.i_rsv_sel);
        rsv_ack     = bus.i_rsv_en && !bus.i_flush &&
                      (!busy_q[bus.i_rsv_sel] || rsv_release || rsv_zero);

        regs_d = regs_q;
        if (bus.i_wr_en && !wr_drop) begin
            regs_d[bus.i_wr_sel] = bus.i_wr_data;
        end

        // Later assignments win: reservation over release, flush over everything.
        busy_d = busy_q;
        if (bus.i_wr_en) begin
            busy_d[bus.i_wr_sel] = 1'b0;
        end
        if (rsv_ack && !rsv_zero) begin
            busy_d[bus.i_rsv_sel] = 1'b1;
        end
        if (bus.i_flush) begin
            busy_d = '0;
        end
        if (ZERO_REG != 0) begin
            busy_d[REG_ZERO] = 1'b0;
        end

        cnt_d = (AW+1)'(popcount(MAX_REGS'(busy_d)));
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.o_rsv_ack  = rsv_ack;
    assign bus.o_busy_cnt = cnt_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   sel;
        logic [XLEN-1:0] data;
        logic            busy;

        assign sel = bus.i_rd_sel[k*AW +: AW];

        regfile_sb_rdport #(
            .XLEN     (XLEN),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rdport (
            .i_sel      (sel),
            .i_wr_en    (bus.i_wr_en),
            .i_wr_sel   (bus.i_wr_sel),
            .i_wr_data  (bus.i_wr_data),
            .i_arr_data (regs_q[sel]),
            .i_arr_busy (busy_q[sel]),
            .o_data     (data),
            .o_busy     (busy)
        );

        assign bus.o_rd_data[k*XLEN +: XLEN] = data;
        assign bus.o_rd_busy[k]              = busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a bypassing 2-port instance and a non-bypassing 4-port instance share stimulus.
module tb_regfile_sb;

    bit   i_CLK = 1'b0;
    logic i_RST;

    always #5 i_CLK = ~i_CLK;

    regfile_sb_if #(.XLEN(32), .NREGS(32), .NUM_RD(2)) bus0 ();
    regfile_sb_if #(.XLEN(32), .NREGS(32), .NUM_RD(4)) bus1 ();

    regfile_sb #(.XLEN(32), .NREGS(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .bus   (bus0.slave)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .NUM_RD(4), .ZERO_REG(1), .BYPASS(0)) dut1 (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .bus   (bus1.slave)
    );

    // Architectural view: contents, pending-result flags and the expected registered count.
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    int          exp_cnt = 0;
    bit          m_valid = 1'b0;

    bit          c_wr_en;
    int          c_wr_sel;
    logic [31:0] c_wr_data;
    int          c_sel [4];

    logic [31:0] s_rd0, s_rd1, s1_rd0;
    logic        s_busy0, s_busy1, s1_busy0, s_ack;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input int sel, input bit byp);
        if (sel == 0)                                  return 32'h0;
        if (byp && c_wr_en && c_wr_sel == sel)         return c_wr_data;
        return m_regs[sel];
    endfunction

    function automatic logic exp_busy(input int sel, input bit byp);
        bit hit;
        hit = c_wr_en && (c_wr_sel == sel);
        if (sel == 0) return 1'b0;
        return byp ? (m_busy[sel] && !hit) : (m_busy[sel] || hit);
    endfunction

    task automatic cyc(input bit rst, input bit wr_en, input int wr_sel, input logic [31:0] wr_data,
                       input bit rsv_en, input int rsv_sel, input bit flush, input int s0, input int s1);
        bit ack;
        int n;
        c_wr_en   = wr_en;
        c_wr_sel  = wr_sel;
        c_wr_data = wr_data;
        c_sel[0]  = s0;
        c_sel[1]  = s1;
        c_sel[2]  = int'($urandom_range(0, 31));
        c_sel[3]  = int'($urandom_range(0, 31));

        i_RST = rst;
        bus0.i_wr_en   = wr_en;   bus1.i_wr_en   = wr_en;
        bus0.i_wr_sel  = 5'(wr_sel);  bus1.i_wr_sel  = 5'(wr_sel);
        bus0.i_wr_data = wr_data; bus1.i_wr_data = wr_data;
        bus0.i_rsv_en  = rsv_en;  bus1.i_rsv_en  = rsv_en;
        bus0.i_rsv_sel = 5'(rsv_sel); bus1.i_rsv_sel = 5'(rsv_sel);
        bus0.i_flush   = flush;   bus1.i_flush   = flush;
        bus0.i_rd_sel  = {5'(s1), 5'(s0)};
        bus1.i_rd_sel  = {5'(c_sel[3]), 5'(c_sel[2]), 5'(s1), 5'(s0)};

        ack = rsv_en && !flush && (!m_busy[rsv_sel] || (wr_en && wr_sel == rsv_sel) || rsv_sel == 0);

        @(negedge i_CLK);
        s_rd0    = bus0.o_rd_data[31:0];
        s_rd1    = bus0.o_rd_data[63:32];
        s_busy0  = bus0.o_rd_busy[0];
        s_busy1  = bus0.o_rd_busy[1];
        s_ack    = bus0.o_rsv_ack;
        s1_rd0   = bus1.o_rd_data[31:0];
        s1_busy0 = bus1.o_rd_busy[0];

        if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                check_eq("byp_rd_data", 64'(bus0.o_rd_data[k*32 +: 32]), 64'(exp_data(c_sel[k], 1'b1)));
                check_eq("byp_rd_busy", 64'(bus0.o_rd_busy[k]), 64'(exp_busy(c_sel[k], 1'b1)));
            end
            for (int k = 0; k < 4; k++) begin
                check_eq("nobyp_rd_data", 64'(bus1.o_rd_data[k*32 +: 32]), 64'(exp_data(c_sel[k], 1'b0)));
                check_eq("nobyp_rd_busy", 64'(bus1.o_rd_busy[k]), 64'(exp_busy(c_sel[k], 1'b0)));
            end
            check_eq("byp_rsv_ack", 64'(bus0.o_rsv_ack), 64'(ack));
            check_eq("nobyp_rsv_ack", 64'(bus1.o_rsv_ack), 64'(ack));
        end

        @(posedge i_CLK);
        #1;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 32'h0;
                m_busy[r] = 1'b0;
            end
        end else begin
            if (wr_en && wr_sel != 0) m_regs[wr_sel] = wr_data;
            if (flush) begin
                for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
            end else begin
                if (wr_en)                m_busy[wr_sel]  = 1'b0;
                if (ack && rsv_sel != 0)  m_busy[rsv_sel] = 1'b1;
            end
        end
        n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
        exp_cnt = n;
        m_valid = 1'b1;

        check_eq("byp_busy_cnt", 64'(bus0.o_busy_cnt), 64'(exp_cnt));
        check_eq("nobyp_busy_cnt", 64'(bus1.o_busy_cnt), 64'(exp_cnt));
    endtask

    task automatic idle(input int s0, input int s1);
        cyc(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0, s0, s1);
    endtask

    function automatic int rnd_sel();
        return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
    endfunction

    initial begin
        cyc(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 0, 0);

        for (int i = 0; i < 32; i++) begin
            idle(i, 31 - i);
            check_eq("rst_rd0", 64'(s_rd0), 64'h0);
            check_eq("rst_busy0", 64'(s_busy0), 64'h0);
        end
        check_eq("rst_cnt", 64'(bus0.o_busy_cnt), 64'h0);

        cyc(1'b0, 1'b1, 0, 32'hDEADBEEF, 1'b0, 0, 1'b0, 0, 0);
        check_eq("x0_write_same", 64'(s_rd0), 64'h0);
        idle(0, 0);
        check_eq("x0_after_write", 64'(s_rd0), 64'h0);

        cyc(1'b0, 1'b1, 5, 32'h12345678, 1'b0, 0, 1'b0, 0, 5);
        check_eq("x5_bypass", 64'(s_rd1), 64'h12345678);
        idle(0, 5);
        check_eq("x5_stored", 64'(s_rd1), 64'h12345678);

        cyc(1'b0, 1'b1, 12, 32'h55, 1'b0, 0, 1'b0, 12, 12);
        check_eq("x12_byp_data", 64'(s_rd0), 64'h55);
        check_eq("x12_byp_busy", 64'(s_busy0), 64'h0);
        check_eq("x12_nobyp_data", 64'(s1_rd0), 64'h0);
        check_eq("x12_nobyp_busy", 64'(s1_busy0), 64'h1);

        cyc(1'b0, 1'b0, 0, 32'h0, 1'b1, 7, 1'b0, 0, 0);
        check_eq("x7_rsv_ack", 64'(s_ack), 64'h1);
        check_eq("x7_cnt1", 64'(bus0.o_busy_cnt), 64'h1);
        idle(7, 0);
        check_eq("x7_busy", 64'(s_busy0), 64'h1);
        cyc(1'b0, 1'b0, 0, 32'h0, 1'b1, 7, 1'b0, 0, 0);
        check_eq("x7_waw_refused", 64'(s_ack), 64'h0);
        cyc(1'b0, 1'b1, 7, 32'hA5, 1'b0, 0, 1'b0, 7, 0);
        check_eq("x7_wb_data", 64'(s_rd0), 64'hA5);
        check_eq("x7_wb_busy", 64'(s_busy0), 64'h0);
        check_eq("x7_cnt0", 64'(bus0.o_busy_cnt), 64'h0);

        cyc(1'b0, 1'b0, 0, 32'h0, 1'b1, 9, 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 9, 32'h1, 1'b1, 9, 1'b0, 0, 0);
        check_eq("x9_rsv_on_release", 64'(s_ack), 64'h1);
        check_eq("x9_cnt_held", 64'(bus0.o_busy_cnt), 64'h1);
        idle(9, 0);
        check_eq("x9_data", 64'(s_rd0), 64'h1);
        check_eq("x9_still_busy", 64'(s_busy0), 64'h1);
        cyc(1'b0, 1'b1, 9, 32'h2, 1'b0, 0, 1'b0, 0, 0);

        cyc(1'b0, 1'b0, 0, 32'h0, 1'b1, 1, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 32'h0, 1'b1, 2, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 32'h0, 1'b1, 3, 1'b0, 0, 0);
        check_eq("three_busy_cnt", 64'(bus0.o_busy_cnt), 64'h3);
        cyc(1'b0, 1'b0, 0, 32'h0, 1'b1, 4, 1'b1, 0, 0);
        check_eq("flush_rsv_ack", 64'(s_ack), 64'h0);
        check_eq("flush_cnt", 64'(bus0.o_busy_cnt), 64'h0);
        idle(1, 2);
        check_eq("flush_busy1", 64'(s_busy0), 64'h0);
        check_eq("flush_busy2", 64'(s_busy1), 64'h0);

        cyc(1'b0, 1'b0, 0, 32'h0, 1'b1, 10, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 10, 32'hFF, 1'b0, 0, 1'b0, 10, 0);
        check_eq("rst_wins_cnt", 64'(bus0.o_busy_cnt), 64'h0);
        idle(10, 0);
        check_eq("rst_wins_data", 64'(s_rd0), 64'h0);
        check_eq("rst_wins_busy", 64'(s_busy0), 64'h0);

        for (int i = 0; i < 400; i++) begin
            int ws;
            ws = rnd_sel();
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, ws, $urandom,
                $urandom_range(0, 2) != 0, ($urandom_range(0, 3) == 0) ? ws : rnd_sel(),
                $urandom_range(0, 19) == 0, rnd_sel(), ($urandom_range(0, 3) == 0) ? ws : rnd_sel());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
